// File: rtl/currctrl_ram_reader.sv
// Block reader: issues credit-limited Avalon-MM word reads over an address range
// and streams the returned words out through a small FIFO, with abort and flush.
module currctrl_ram_reader #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         remain_q, remain_d;
    logic                    read_q, read_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0]       mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

    logic          accept_s, ret_s, pop_s, start_ok_s, last_s, drain_empty_s, credit_s;
    logic [CW-1:0] inflight_nf_s, cnt_nf_s;

    // ret_s marks the cycle in which avm_readdata belongs to a read accepted READ_LATENCY edges ago
    assign accept_s      = read_q & ~avm_waitrequest;
    assign ret_s         = pipe_q[READ_LATENCY-1];
    assign pop_s         = (count_q != {CW{1'b0}}) & out_ready;
    assign start_ok_s    = start & ~abort & (state_q == IDLE);
    assign last_s        = accept_s & (remain_q == (ADDR_W+1)'(1'b1));
    assign inflight_nf_s = inflight_q + CW'(accept_s) - CW'(ret_s);
    assign cnt_nf_s      = count_q + CW'(ret_s) - CW'(pop_s);
    assign drain_empty_s = (inflight_nf_s == {CW{1'b0}}) && (cnt_nf_s == {CW{1'b0}});

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok_s && (word_count != {(ADDR_W+1){1'b0}})) state_d = RUN;
                else                                                 state_d = IDLE;
            end
            RUN: begin
                if (abort)       state_d = FLUSH;
                else if (last_s) state_d = DRAIN;
                else             state_d = RUN;
            end
            DRAIN: begin
                if (abort)              state_d = FLUSH;
                else if (drain_empty_s) state_d = IDLE;
                else                    state_d = DRAIN;
            end
            FLUSH: begin
                if ((inflight_q == {CW{1'b0}}) && !read_q) state_d = IDLE;
                else                                       state_d = FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/count tracking, return pipeline and FIFO; entering or staying in FLUSH empties the FIFO
    always_comb begin
        inflight_d = inflight_nf_s;
        pipe_d     = pipe_q << 1'b1;
        pipe_d[0]  = accept_s;
        mem_d      = mem_q;
        if (start_ok_s) begin
            addr_d   = base_addr;
            remain_d = word_count;
        end else if (accept_s) begin
            addr_d   = addr_q + ADDR_W'(1'b1);
            remain_d = remain_q - (ADDR_W+1)'(1'b1);
        end else begin
            addr_d   = addr_q;
            remain_d = remain_q;
        end
        if (state_d == FLUSH) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (ret_s) begin
                mem_d[wr_ptr_q] = avm_readdata;
                wr_ptr_d        = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1'b1);
            else       rd_ptr_d = rd_ptr_q;
            count_d = cnt_nf_s;
        end
    end

    // Output logic: a stalled read is always held; a new one needs credit against next-cycle occupancy
    always_comb begin
        credit_s = ({1'b0, inflight_nf_s} + {1'b0, count_d}) < (CW+1)'(FIFO_DEPTH);
        if (read_q && avm_waitrequest)                                                 read_d = 1'b1;
        else if ((state_d == RUN) && (remain_d != {(ADDR_W+1){1'b0}}) && credit_s)     read_d = 1'b1;
        else                                                                           read_d = 1'b0;
        busy_d    = (state_d != IDLE);
        done_d    = (start_ok_s && (word_count == {(ADDR_W+1){1'b0}})) ||
                    ((state_q == DRAIN) && (state_d == IDLE));
        aborted_d = (state_q == FLUSH) && (state_d == IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            remain_q   <= {(ADDR_W+1){1'b0}};
            read_q     <= 1'b0;
            inflight_q <= {CW{1'b0}};
            pipe_q     <= {READ_LATENCY{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            read_q     <= read_d;
            inflight_q <= inflight_d;
            pipe_q     <= pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_chipselect = read_q;
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign out_valid      = (count_q != {CW{1'b0}});
    assign out_data       = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_currctrl_ram_reader.sv
// Directed bench for currctrl_ram_reader: RAM model with word[i]=i*3, stream and
// bus monitors, and immediate-assertion checks of hand-computed expectations.
module tb_currctrl_ram_reader;
    logic        clk = 1'b0;
    logic        reset_n, start, abort, out_ready;
    logic [7:0]  base_addr;
    logic [8:0]  word_count;
    logic        busy, done, aborted, avm_chipselect, avm_read, avm_write, avm_waitrequest, out_valid;
    logic [7:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata, out_data;

    int tests = 0, fails = 0, cyc = 0;
    int done_cnt = 0, aborted_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
    int acc_cnt_p = 0, stall_cnt = 0, wait_idx = -1, stall_tgt = 0;
    logic [31:0] xfer_q[$];
    logic [7:0]  acc_addr_q[$];
    logic [7:0]  stall_addr_q[$];

    currctrl_ram_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .aborted(aborted),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read(avm_read),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Stall only the selected read, for a bounded number of cycles
    assign avm_waitrequest = avm_read && (acc_cnt_p == wait_idx) && (stall_cnt < stall_tgt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        avm_readdata <= (avm_read && !avm_waitrequest) ? ({24'd0, avm_address} * 32'd3) : 32'hDEADBEEF;
        if (avm_read && !avm_waitrequest) acc_cnt_p <= acc_cnt_p + 1;
        if (avm_read && avm_waitrequest)  stall_cnt <= stall_cnt + 1;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                xfer_q.push_back(out_data);
                last_xfer_cyc = cyc;
            end
            if (avm_read && !avm_waitrequest) acc_addr_q.push_back(avm_address);
            if (avm_read && avm_waitrequest)  stall_addr_q.push_back(avm_address);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (aborted) aborted_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] n);
        start = 1'b1;
        base_addr = b;
        word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
        check({tag, "_read"}, {31'd0, avm_read}, 32'd0);
        check({tag, "_cs"}, {31'd0, avm_chipselect}, 32'd0);
        check({tag, "_addr"}, {24'd0, avm_address}, 32'd0);
        check({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_odata"}, out_data, 32'd0);
    endtask

    initial begin
        int xb, ab, db, abb, sb, rd_seen, ov_seen;
        logic [31:0] exp5 [5];
        exp5 = '{32'h30, 32'h33, 32'h36, 32'h39, 32'h3C};
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = 8'h00; word_count = 9'd0;
        tick(); tick();
        check_reset_outputs("rst");
        check("tied_write", {31'd0, avm_write}, 32'd0);
        check("tied_be", {28'd0, avm_byteenable}, 32'hF);
        reset_n = 1'b1;
        tick();

        // Basic block
        xb = xfer_q.size(); db = done_cnt;
        do_start(8'h10, 9'd5);
        check("basic_busy", {31'd0, busy}, 32'd1);
        wait_done(db + 1, 60);
        repeat (3) tick();
        check("basic_nwords", xfer_q.size() - xb, 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("basic_w%0d", i), xfer_q[xb + i], exp5[i]);
        check("basic_done_once", done_cnt - db, 32'd1);
        check("basic_done_lat", done_cyc - last_xfer_cyc, 32'd1);
        check("basic_busy_low", {31'd0, busy}, 32'd0);

        // Address wrap
        xb = xfer_q.size(); ab = acc_addr_q.size(); db = done_cnt;
        do_start(8'hFE, 9'd4);
        wait_done(db + 1, 60);
        check("wrap_nreads", acc_addr_q.size() - ab, 32'd4);
        check("wrap_a0", {24'd0, acc_addr_q[ab]},     32'hFE);
        check("wrap_a1", {24'd0, acc_addr_q[ab + 1]}, 32'hFF);
        check("wrap_a2", {24'd0, acc_addr_q[ab + 2]}, 32'h00);
        check("wrap_a3", {24'd0, acc_addr_q[ab + 3]}, 32'h01);
        check("wrap_d0", xfer_q[xb],     32'h2FA);
        check("wrap_d1", xfer_q[xb + 1], 32'h2FD);
        check("wrap_d2", xfer_q[xb + 2], 32'h000);
        check("wrap_d3", xfer_q[xb + 3], 32'h003);

        // Backpressure: credit limits reads to the FIFO depth
        out_ready = 1'b0;
        xb = xfer_q.size(); ab = acc_addr_q.size(); db = done_cnt;
        do_start(8'h20, 9'd10);
        repeat (15) tick();
        check("bp_nreads", acc_addr_q.size() - ab, 32'd4);
        check("bp_read_low", {31'd0, avm_read}, 32'd0);
        check("bp_ovalid", {31'd0, out_valid}, 32'd1);
        check("bp_head", out_data, 32'h60);
        out_ready = 1'b1;
        wait_done(db + 1, 100);
        check("bp_nwords", xfer_q.size() - xb, 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("bp_w%0d", i), xfer_q[xb + i], (32'h20 + i) * 32'd3);

        // Waitrequest held for 3 cycles on the 2nd read
        xb = xfer_q.size(); ab = acc_addr_q.size(); db = done_cnt; sb = stall_addr_q.size();
        wait_idx = acc_cnt_p + 1;
        stall_tgt = stall_cnt + 3;
        do_start(8'h40, 9'd4);
        wait_done(db + 1, 60);
        check("wr_nstall", stall_addr_q.size() - sb, 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("wr_hold%0d", i), {24'd0, stall_addr_q[sb + i]}, 32'h41);
        check("wr_a1", {24'd0, acc_addr_q[ab + 1]}, 32'h41);
        check("wr_d0", xfer_q[xb],     32'hC0);
        check("wr_d1", xfer_q[xb + 1], 32'hC3);
        check("wr_d2", xfer_q[xb + 2], 32'hC6);
        check("wr_d3", xfer_q[xb + 3], 32'hC9);

        // Abort after 6 transfers
        xb = xfer_q.size(); db = done_cnt; abb = aborted_cnt;
        do_start(8'h50, 9'd20);
        for (int i = 0; i < 100; i++) begin
            if (xfer_q.size() - xb >= 6) break;
            tick();
        end
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_read_stop", {31'd0, avm_read}, 32'd0);
        ab = acc_addr_q.size();
        rd_seen = 0; ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            rd_seen += int'(avm_read);
            ov_seen += int'(out_valid);
            tick();
        end
        check("ab_no_reads", rd_seen + (acc_addr_q.size() - ab), 32'd0);
        check("ab_ovalid_low", ov_seen, 32'd0);
        check("ab_aborted_once", aborted_cnt - abb, 32'd1);
        check("ab_no_done", done_cnt - db, 32'd0);
        check("ab_busy_low", {31'd0, busy}, 32'd0);
        check("ab_nwords", xfer_q.size() - xb, 32'd6);
        check("ab_w0", xfer_q[xb],     32'hF0);
        check("ab_w5", xfer_q[xb + 5], 32'hFF);
        out_ready = 1'b1;
        xb = xfer_q.size(); db = done_cnt;
        do_start(8'h00, 9'd2);
        wait_done(db + 1, 60);
        check("ab_next_n", xfer_q.size() - xb, 32'd2);
        check("ab_next_w0", xfer_q[xb],     32'h0);
        check("ab_next_w1", xfer_q[xb + 1], 32'h3);

        // Zero-length block
        ab = acc_addr_q.size(); db = done_cnt;
        do_start(8'h30, 9'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        tick();
        check("zero_done_pulse", {31'd0, done}, 32'd0);
        tick();
        check("zero_reads", acc_addr_q.size() - ab, 32'd0);
        check("zero_done_once", done_cnt - db, 32'd1);

        // start together with abort in IDLE is ignored
        db = done_cnt;
        start = 1'b1; abort = 1'b1; base_addr = 8'h00; word_count = 9'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        check("sa_no_done", done_cnt - db, 32'd0);

        // start while busy is ignored
        xb = xfer_q.size(); db = done_cnt;
        do_start(8'h60, 9'd3);
        do_start(8'h80, 9'd5);
        wait_done(db + 1, 60);
        repeat (4) tick();
        check("sb_nwords", xfer_q.size() - xb, 32'd3);
        check("sb_w0", xfer_q[xb],     32'h120);
        check("sb_w2", xfer_q[xb + 2], 32'h126);
        check("sb_done_once", done_cnt - db, 32'd1);

        // Asynchronous reset mid-RUN
        out_ready = 1'b0;
        do_start(8'h70, 9'd20);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        db = done_cnt; abb = aborted_cnt;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();
        check("midrst_no_done", done_cnt - db, 32'd0);
        check("midrst_no_abort", aborted_cnt - abb, 32'd0);
        out_ready = 1'b1;
        xb = xfer_q.size(); db = done_cnt;
        do_start(8'h05, 9'd1);
        wait_done(db + 1, 40);
        check("midrst_nwords", xfer_q.size() - xb, 32'd1);
        check("midrst_w0", xfer_q[xb], 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
